// File: rtl/sgbm_pkg.sv
// rtl/sgbm_pkg.sv - shared SGBM geometry, cost and disparity constants
package sgbm_pkg;

  localparam int IMG_W    = 400;
  localparam int IMG_H    = 200;
  localparam int MAX_DISP = 64;
  localparam int COST_W   = 16;
  localparam int D_W      = $clog2(MAX_DISP);
  localparam int ROW_W    = 10;
  localparam int COL_W    = 10;

  localparam logic [31:0] INVALID_DISP = 32'h0;

endpackage

// File: rtl/raster_cnt.sv
// rtl/raster_cnt.sv - row/col raster position counters with frame_end strobe
module raster_cnt
  import sgbm_pkg::*;
#(
  parameter int IMG_W = sgbm_pkg::IMG_W,
  parameter int IMG_H = sgbm_pkg::IMG_H
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             advance_i,
  output logic [ROW_W-1:0] row_o,
  output logic [COL_W-1:0] col_o,
  output logic             frame_end_o
);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic             col_last, row_last;

  assign col_last = (col_q == COL_LAST);
  assign row_last = (row_q == ROW_LAST);

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (advance_i) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  // Position reported is the one of the pixel being advanced past.
  assign row_o       = row_q;
  assign col_o       = col_q;
  assign frame_end_o = advance_i & col_last & row_last;

endmodule

// File: rtl/disp_wta.sv
// rtl/disp_wta.sv - winner-take-all disparity selector over serial cost bursts
// Optional UNIQUENESS_CHECK_EN: reject ambiguous minima, adds one pipeline stage.
module disp_wta
  import sgbm_pkg::*;
#(
  parameter int          MAX_DISP     = sgbm_pkg::MAX_DISP,
  parameter int          COST_W       = sgbm_pkg::COST_W,
  parameter int          IMG_W        = sgbm_pkg::IMG_W,
  parameter int          IMG_H        = sgbm_pkg::IMG_H,
  parameter int          UNIQ_RATIO   = 10,
  parameter logic [31:0] INVALID_DISP = sgbm_pkg::INVALID_DISP
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [COST_W-1:0] cost_in,
  input  logic              cost_valid,
  input  logic              cost_sop,
  output logic [31:0]       disparity,
  output logic [ROW_W-1:0]  row_out,
  output logic [COL_W-1:0]  col_out,
  output logic              disp_valid,
  output logic              frame_end,
  output logic              sync_err
);

  localparam int            DW   = $clog2(MAX_DISP);
  localparam int            CW   = DW + 1;
  localparam int            PADW = 32 - DW;
  localparam logic [CW-1:0] D_LAST = CW'(MAX_DISP - 1);

  logic [CW-1:0]     d_cnt_q, d_cnt_d;
  logic [COST_W-1:0] best_cost_q, best_cost_d;
  logic [DW-1:0]     best_idx_q, best_idx_d;
  logic              sync_err_q, sync_err_d;
  logic              close;
`ifdef UNIQUENESS_CHECK_EN
  logic [COST_W-1:0] sec_cost_q, sec_cost_d;
`endif

  logic [ROW_W-1:0] row_cur;
  logic [COL_W-1:0] col_cur;
  logic             fe_cur;

  logic             out_fire, out_fe;
  logic [31:0]      out_disp;
  logic [ROW_W-1:0] out_row;
  logic [COL_W-1:0] out_col;

  logic             disp_valid_q, frame_end_q;
  logic [31:0]      disparity_q;
  logic [ROW_W-1:0] row_out_q;
  logic [COL_W-1:0] col_out_q;

  // The _d values on the closing beat already include that beat's comparison.
  always_comb begin
    d_cnt_d     = d_cnt_q;
    best_cost_d = best_cost_q;
    best_idx_d  = best_idx_q;
    sync_err_d  = sync_err_q;
    close       = 1'b0;
`ifdef UNIQUENESS_CHECK_EN
    sec_cost_d  = sec_cost_q;
`endif
    if (cost_valid) begin
      if (cost_sop) begin
        if (d_cnt_q != '0) sync_err_d = 1'b1;
        best_cost_d = cost_in;
        best_idx_d  = '0;
`ifdef UNIQUENESS_CHECK_EN
        sec_cost_d  = '1;
`endif
        d_cnt_d     = CW'(1);
      end else if (d_cnt_q == '0) begin
        sync_err_d = 1'b1;
      end else begin
        if (cost_in < best_cost_q) begin
`ifdef UNIQUENESS_CHECK_EN
          sec_cost_d  = best_cost_q;
`endif
          best_cost_d = cost_in;
          best_idx_d  = d_cnt_q[DW-1:0];
        end
`ifdef UNIQUENESS_CHECK_EN
        else if (cost_in < sec_cost_q) begin
          sec_cost_d = cost_in;
        end
`endif
        if (d_cnt_q == D_LAST) begin
          close   = 1'b1;
          d_cnt_d = '0;
        end else begin
          d_cnt_d = d_cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_cnt_q     <= '0;
      best_cost_q <= '0;
      best_idx_q  <= '0;
      sync_err_q  <= 1'b0;
`ifdef UNIQUENESS_CHECK_EN
      sec_cost_q  <= '1;
`endif
    end else begin
      d_cnt_q     <= d_cnt_d;
      best_cost_q <= best_cost_d;
      best_idx_q  <= best_idx_d;
      sync_err_q  <= sync_err_d;
`ifdef UNIQUENESS_CHECK_EN
      sec_cost_q  <= sec_cost_d;
`endif
    end
  end

  raster_cnt #(
    .IMG_W(IMG_W),
    .IMG_H(IMG_H)
  ) u_raster (
    .clk_i      (clk),
    .rst_i      (rst),
    .advance_i  (close),
    .row_o      (row_cur),
    .col_o      (col_cur),
    .frame_end_o(fe_cur)
  );

`ifdef UNIQUENESS_CHECK_EN
  localparam int PW = COST_W + 8;

  logic              s1_valid_q, s1_fe_q;
  logic [COST_W-1:0] s1_best_q, s1_sec_q;
  logic [DW-1:0]     s1_idx_q;
  logic [ROW_W-1:0]  s1_row_q;
  logic [COL_W-1:0]  s1_col_q;
  logic [PW-1:0]     sec_scaled, best_scaled;
  logic              ambiguous;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_fe_q    <= 1'b0;
      s1_best_q  <= '0;
      s1_sec_q   <= '0;
      s1_idx_q   <= '0;
      s1_row_q   <= '0;
      s1_col_q   <= '0;
    end else begin
      s1_valid_q <= close;
      s1_fe_q    <= fe_cur;
      if (close) begin
        s1_best_q <= best_cost_d;
        s1_sec_q  <= sec_cost_d;
        s1_idx_q  <= best_idx_d;
        s1_row_q  <= row_cur;
        s1_col_q  <= col_cur;
      end
    end
  end

  // Runner-up within UNIQ_RATIO percent of the winner makes the match ambiguous.
  always_comb begin
    sec_scaled  = PW'(s1_sec_q) * PW'(100);
    best_scaled = PW'(s1_best_q) * PW'(100 + UNIQ_RATIO);
    ambiguous   = (sec_scaled < best_scaled);
    out_fire    = s1_valid_q;
    out_fe      = s1_fe_q;
    out_row     = s1_row_q;
    out_col     = s1_col_q;
    out_disp    = ambiguous ? INVALID_DISP : {{PADW{1'b0}}, s1_idx_q};
  end
`else
  always_comb begin
    out_fire = close;
    out_fe   = fe_cur;
    out_row  = row_cur;
    out_col  = col_cur;
    out_disp = {{PADW{1'b0}}, best_idx_d};
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_valid_q <= 1'b0;
      frame_end_q  <= 1'b0;
      disparity_q  <= '0;
      row_out_q    <= '0;
      col_out_q    <= '0;
    end else begin
      disp_valid_q <= out_fire;
      frame_end_q  <= out_fe;
      if (out_fire) begin
        disparity_q <= out_disp;
        row_out_q   <= out_row;
        col_out_q   <= out_col;
      end
    end
  end

  assign disparity  = disparity_q;
  assign row_out    = row_out_q;
  assign col_out    = col_out_q;
  assign disp_valid = disp_valid_q;
  assign frame_end  = frame_end_q;
  assign sync_err   = sync_err_q;

endmodule

// File: doc/disp_wta.md
# disp_wta

Winner-take-all disparity selector for the SGBM pipeline. Consumes the aggregated matching cost of each pixel as a serial burst of `MAX_DISP` beats, one candidate disparity per cycle, and selects the minimum-cost disparity. Tracks raster position and emits `disparity`, `row_out`, `col_out` and a one-cycle `disp_valid` that drive the downstream BRAM writer directly. The writer has no back-pressure, so this block never stalls.

## Interface
- `MAX_DISP`, 64: candidate disparities per pixel, ≥2; `D_W = $clog2(MAX_DISP)`.
- `COST_W`, 16: unsigned aggregated cost width.
- `IMG_W`, 400: pixels per row.
- `IMG_H`, 200: rows per frame.
- `UNIQ_RATIO`, 10: uniqueness margin in percent (used only with the macro).
- `INVALID_DISP`, 32'h0: code emitted for rejected pixels.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `cost_in` in `COST_W`: aggregated cost of the current candidate.
- `cost_valid` in 1: `cost_in` is valid this cycle.
- `cost_sop` in 1: with `cost_valid`, marks candidate d=0 of a new pixel.
- `disparity` out 32: selected disparity, zero-extended from `D_W`.
- `row_out` out 10: row of the emitted pixel.
- `col_out` out 10: column of the emitted pixel.
- `disp_valid` out 1: one-cycle strobe; outputs are valid.
- `frame_end` out 1: asserted with `disp_valid` for pixel (`IMG_H`-1, `IMG_W`-1).
- `sync_err` out 1: sticky framing-error flag, cleared only by `rst`.

## Operation
- The sweep counter `d_cnt` (`D_W`+1 bits) equals 0 when idle.
- **Beat with `cost_sop`:**
  - `best`=`cost_in`, `best_d`=0, `second`=all-ones, `d_cnt`=1.
- **Beat without `sop` and `d_cnt`≠0:**
  - If `cost_in` < `best` (strict): `second`=`best`, `best`=`cost_in`, `best_d`=`d_cnt`.
  - Else if `cost_in` < `second`: `second`=`cost_in`.
  - Then increment `d_cnt`.
- **Tie rule:** the lowest d wins.
- **Final beat:** the beat at `d_cnt`=`MAX_DISP`-1 closes the pixel.
  - The comparison includes this beat.
  - Result is registered and `d_cnt` returns to 0.
- **Raster counters:**
  - `col` increments per emitted pixel; at `IMG_W`-1 it wraps to 0 and `row` increments.
  - At (`IMG_H`-1, `IMG_W`-1) both wrap to 0 and `frame_end` pulses.
- **Framing errors:**
  - Beat without `sop` while idle: dropped, `sync_err` set.
  - `sop` while `d_cnt`≠0: the partial pixel is discarded with no output and no counter advance; `sync_err` set; the new pixel starts.
- **Gaps:** `cost_valid` low holds all state, so gaps inside a sweep are legal.
- **`MAX_DISP` beats always produce exactly one output pixel.**

## Timing
- **Reset values:** `disparity`=0, `row_out`=0, `col_out`=0, `disp_valid`=0, `frame_end`=0, `sync_err`=0. Internal `d_cnt`, `row` and `col` are also 0.
- **Latency:** final beat at cycle t gives `disp_valid` at t+1 for exactly one cycle.
- **Output hold:** `disparity`, `row_out` and `col_out` hold their values until the next strobe.
- **Back-to-back pixels:** a `sop` at t+1 is accepted in the same cycle the previous result is emitted. The result is one pixel per `MAX_DISP` cycles.
- **Reset mid-sweep:** the partial pixel is lost. The first pixel after reset is (0,0).

## Configuration
- **`UNIQUENESS_CHECK_EN` defined:**
  - On the final beat, compute `second`·100 < `best`·(100+`UNIQ_RATIO`). Use `COST_W`+8-bit unsigned products with no overflow.
  - If true, emit `INVALID_DISP`.
  - Position counters and `disp_valid` are unaffected.
  - Adds one compare cycle, so latency becomes t+2. Back-to-back throughput is unchanged (pipelined).
- **Not defined:**
  - `second` tracking and `UNIQ_RATIO` are not synthesized.
  - Latency is t+1 and the selected `best_d` is always emitted.

## Structure
- **Shared package `sgbm_pkg`:** `IMG_W`, `IMG_H`, `MAX_DISP`, `COST_W`, `D_W`, `INVALID_DISP`. Shared with the cost aggregator and `ram_rw`-side logic.
- **Sub-module `raster_cnt`:** row/col counters with wrap and `frame_end` generation, advanced by an `advance` strobe. It is reused by the upstream census stage.

## Test plan
- **Basic selection:** pixel with costs 100−d except d=17 at cost 5 → `disparity`=17, `disp_valid` one cycle after beat 63, `row_out`=0, `col_out`=0.
- **Tie-break:** equal minimum 3 at d=4 and d=40 → `disparity`=4.
- **Full frame:** 80000 back-to-back pixels → 80000 strobes. The last has row 199, col 399 and `frame_end`=1. The next pixel reports (0,0). There are no idle cycles between strobes.
- **Framing errors:** `sop` at beat 30, then a full 64-beat pixel → exactly one strobe for the second pixel, `col_out`=0, `sync_err`=1. Also check that a lone non-`sop` beat while idle sets `sync_err` with no strobe.
- **Uniqueness (macro on, ratio 10):**
  - best 100, second 105 → `INVALID_DISP`.
  - best 100, second 115 → `best_d`.
  - Latency is 2.
- **Async reset:** `rst` pulsed mid-sweep, off-edge → outputs 0 immediately. The next full pixel yields (0,0) and `sync_err`=0.
